// File: rtl/score_ram_scheduler.sv
// Score RAM scheduler: arbitrates the single-port user-score RAM between the
// game FSM write-back port and the score-browse reader that feeds the hex display.
// Write-back always wins; a browse read blocked by a write is remembered (one deep)
// and issued as soon as the RAM is free again.
module score_ram_scheduler #(
  parameter int NUM_USERS  = 6,
  parameter int RAM_RD_LAT = 2,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               access_granted,
  input  logic               scoreRst,
  input  logic               ac_button,
  input  logic               wr_req,
  input  logic [2:0]         wr_userID,
  input  logic [SCORE_W-1:0] wr_score,
  output logic               wr_ack,
  output logic [2:0]         ram_addr,
  output logic               ram_we,
  output logic [SCORE_W-1:0] ram_wdata,
  input  logic [SCORE_W-1:0] ram_rdata,
  output logic [2:0]         userID,
  output logic [SCORE_W-1:0] currentUserScoreFromRam,
  output logic               score_valid,
  output logic               busy
);

  localparam int               CNT_W     = $clog2(RAM_RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(RAM_RD_LAT);
  localparam logic [2:0]       LAST_USER = 3'(NUM_USERS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               access_q;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [2:0]         user_q, user_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               valid_q, valid_d;
  logic [2:0]         addr_q, addr_d;
  logic               we_q, we_d;
  logic [SCORE_W-1:0] wdata_q, wdata_d;
  logic               ack_q, ack_d;

  logic access_rise;
  logic access_fall;
  logic press;
  logic take_press;

  // A login edge overrides a press in the same cycle; a press is only taken when
  // no earlier request is still waiting, which keeps the backlog one deep.
  assign access_rise = access_granted & ~access_q;
  assign access_fall = ~access_granted & access_q;
  assign press       = access_granted & scoreRst & ac_button & ~access_rise;
  assign take_press  = press & ~pending_q;

  // State and datapath registers, all cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      access_q  <= 1'b0;
      pending_q <= 1'b0;
      rd_cnt_q  <= '0;
      user_q    <= '0;
      score_q   <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      access_q  <= access_granted;
      pending_q <= pending_d;
      rd_cnt_q  <= rd_cnt_d;
      user_q    <= user_d;
      score_q   <= score_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
    end
  end

  // Next-state logic: writes beat reads in IDLE, and a logout aborts a read in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_req)
          state_d = WRITE;
        else if ((pending_q && access_granted) || take_press)
          state_d = RD_ISSUE;
      end
      WRITE:    state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (rd_cnt_q == LAST_CNT) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (access_fall && (state_q == RD_ISSUE || state_q == RD_WAIT))
      state_d = IDLE;
  end

  // Output and datapath next values: RAM strobes, browse pointer, capture and backlog.
  // The backlog flag is cleared when a read is issued so a press that lands while
  // the read is in flight re-arms it; such a capture is then stale and stays invalid.
  always_comb begin
    pending_d = pending_q;
    rd_cnt_d  = rd_cnt_q;
    user_d    = user_q;
    score_d   = score_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_req) begin
          addr_d  = wr_userID;
          wdata_d = wr_score;
          we_d    = (wr_userID <= LAST_USER);
          ack_d   = 1'b1;
        end
      end
      WRITE: begin
        if (addr_q == user_q && access_granted) begin
          valid_d   = 1'b0;
          pending_d = 1'b1;
        end
      end
      RD_ISSUE: begin
        addr_d    = user_q;
        rd_cnt_d  = '0;
        pending_d = 1'b0;
      end
      RD_WAIT: begin
        if (rd_cnt_q == LAST_CNT) begin
          score_d = ram_rdata;
          valid_d = ~pending_q;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (take_press) begin
      user_d  = (user_q == LAST_USER) ? 3'd0 : user_q + 3'd1;
      valid_d = 1'b0;
      if (state_q != IDLE || wr_req)
        pending_d = 1'b1;
    end

    if (access_rise) begin
      user_d    = 3'd0;
      valid_d   = 1'b0;
      pending_d = 1'b1;
    end

    if (access_fall) begin
      user_d    = 3'd0;
      valid_d   = 1'b0;
      pending_d = 1'b0;
      score_d   = score_q;
    end
  end

  assign wr_ack                  = ack_q;
  assign ram_addr                = addr_q;
  assign ram_we                  = we_q;
  assign ram_wdata               = wdata_q;
  assign userID                  = user_q;
  assign currentUserScoreFromRam = score_q;
  assign score_valid             = valid_q;
  assign busy                    = (state_q != IDLE);

endmodule

// File: tb/tb_score_ram_scheduler.sv
// Testbench for score_ram_scheduler: a behavioural RAM with fixed read latency,
// a reference score table and browse pointer kept with plain arithmetic, and one
// task per scenario. Inputs are driven and outputs sampled on the falling edge.
module tb_score_ram_scheduler;

  localparam int NUM_USERS  = 6;
  localparam int RAM_RD_LAT = 2;
  localparam int SCORE_W    = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               access_granted;
  logic               scoreRst;
  logic               ac_button;
  logic               wr_req;
  logic [2:0]         wr_userID;
  logic [SCORE_W-1:0] wr_score;
  logic               wr_ack;
  logic [2:0]         ram_addr;
  logic               ram_we;
  logic [SCORE_W-1:0] ram_wdata;
  logic [SCORE_W-1:0] ram_rdata;
  logic [2:0]         userID;
  logic [SCORE_W-1:0] currentUserScoreFromRam;
  logic               score_valid;
  logic               busy;

  logic [SCORE_W-1:0] ram_mem [0:7];
  logic [SCORE_W-1:0] rd_pipe [0:RAM_RD_LAT-1];
  logic               pre_en;
  logic [2:0]         pre_addr;
  logic [SCORE_W-1:0] pre_data;

  logic [SCORE_W-1:0] ref_mem [0:7];
  int                 exp_uid;
  int                 n_checks = 0;
  int                 n_fails  = 0;

  score_ram_scheduler #(
    .NUM_USERS (NUM_USERS),
    .RAM_RD_LAT(RAM_RD_LAT),
    .SCORE_W   (SCORE_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .access_granted         (access_granted),
    .scoreRst               (scoreRst),
    .ac_button              (ac_button),
    .wr_req                 (wr_req),
    .wr_userID              (wr_userID),
    .wr_score               (wr_score),
    .wr_ack                 (wr_ack),
    .ram_addr               (ram_addr),
    .ram_we                 (ram_we),
    .ram_wdata              (ram_wdata),
    .ram_rdata              (ram_rdata),
    .userID                 (userID),
    .currentUserScoreFromRam(currentUserScoreFromRam),
    .score_valid            (score_valid),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM: address sampled at an edge, data readable RAM_RD_LAT edges later.
  always @(posedge clk) begin
    if (pre_en)
      ram_mem[pre_addr] <= pre_data;
    else if (ram_we)
      ram_mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RAM_RD_LAT; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RAM_RD_LAT-1];

  function automatic int next_uid(input int u);
    return (u + 1) % NUM_USERS;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input int idx, input logic [SCORE_W-1:0] d);
    pre_en   = 1'b1;
    pre_addr = 3'(idx);
    pre_data = d;
    ref_mem[idx] = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic do_press();
    ac_button = 1'b1;
    tick();
    ac_button = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (score_valid === 1'b1 && busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  // Holds wr_req until the acknowledge is seen, returning in the WRITE cycle.
  task automatic do_write(input int slot, input logic [SCORE_W-1:0] d, output bit got);
    wr_req    = 1'b1;
    wr_userID = 3'(slot);
    wr_score  = d;
    got       = 1'b0;
    for (int i = 0; i < RAM_RD_LAT + 8; i++) begin
      tick();
      if (wr_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    wr_req = 1'b0;
    if (got && slot < NUM_USERS) ref_mem[slot] = d;
  endtask

  task automatic goto_user(input int target);
    bit to;
    for (int k = 0; k < NUM_USERS && exp_uid != target; k++) begin
      do_press();
      exp_uid = next_uid(exp_uid);
      wait_valid(20, to);
    end
  endtask

  task automatic test_reset();
    bit to;
    rst = 1'b0; access_granted = 1'b1; scoreRst = 1'b1; ac_button = 1'b0;
    wr_req = 1'b0; wr_userID = 3'd0; wr_score = '0;
    pre_en = 1'b0; pre_addr = 3'd0; pre_data = '0;
    tick();
    for (int i = 0; i < 8; i++)
      preload(i, (i == 1) ? 8'h24 : ((i < NUM_USERS) ? 8'($urandom) : 8'h00));
    n_checks++; if (userID !== 3'd0) begin n_fails++; $display("[TB] FAIL reset_userID: got %0d expected 0", userID); end
    n_checks++; if (currentUserScoreFromRam !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_score: got %0h expected 0", currentUserScoreFromRam); end
    n_checks++; if (score_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", score_valid); end
    n_checks++; if (ram_we !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ram_we: got %0b expected 0", ram_we); end
    n_checks++; if (ram_addr !== 3'd0) begin n_fails++; $display("[TB] FAIL reset_ram_addr: got %0d expected 0", ram_addr); end
    n_checks++; if (ram_wdata !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_ram_wdata: got %0h expected 0", ram_wdata); end
    n_checks++; if (wr_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_wr_ack: got %0b expected 0", wr_ack); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    rst = 1'b1;
    exp_uid = 0;
    wait_valid(20, to);
    n_checks++; if (to) begin n_fails++; $display("[TB] FAIL login_autoread_timeout: got timeout expected capture"); end
    n_checks++; if (userID !== 3'd0) begin n_fails++; $display("[TB] FAIL login_autoread_uid: got %0d expected 0", userID); end
    n_checks++; if (currentUserScoreFromRam !== ref_mem[0]) begin n_fails++; $display("[TB] FAIL login_autoread_score: got %0h expected %0h", currentUserScoreFromRam, ref_mem[0]); end
  endtask

  task automatic test_first_press();
    do_press();
    exp_uid = next_uid(exp_uid);
    n_checks++; if (userID !== 3'(exp_uid)) begin n_fails++; $display("[TB] FAIL press_uid: got %0d expected %0d", userID, exp_uid); end
    n_checks++; if (score_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL press_valid_drop: got %0b expected 0", score_valid); end
    tick();
    n_checks++; if (ram_addr !== 3'(exp_uid) || ram_we !== 1'b0) begin n_fails++; $display("[TB] FAIL press_issue_addr: got addr %0d we %0b expected addr %0d we 0", ram_addr, ram_we, exp_uid); end
    tick(); tick();
    n_checks++; if (score_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL press_valid_early: got %0b expected 0 at E0+3", score_valid); end
    tick();
    n_checks++; if (score_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL press_valid_latency: got %0b expected 1 at E0+4", score_valid); end
    n_checks++; if (currentUserScoreFromRam !== 8'h24) begin n_fails++; $display("[TB] FAIL press_score: got %0h expected 24", currentUserScoreFromRam); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NUM_USERS; i++) preload(i, 8'(i * 16));
    for (int p = 0; p < 12; p++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      do_press();
      exp_uid = next_uid(exp_uid);
      tick(); tick(); tick(); tick();
      n_checks++; if (userID !== 3'(exp_uid)) begin n_fails++; $display("[TB] FAIL rr_uid: press %0d got %0d expected %0d", p, userID, exp_uid); end
      n_checks++; if (score_valid !== 1'b1 || currentUserScoreFromRam !== ref_mem[exp_uid]) begin n_fails++; $display("[TB] FAIL rr_capture: press %0d got valid %0b score %0h expected valid 1 score %0h", p, score_valid, currentUserScoreFromRam, ref_mem[exp_uid]); end
    end
  endtask

  task automatic test_press_with_write();
    bit to;
    goto_user(2);
    ac_button = 1'b1; wr_req = 1'b1; wr_userID = 3'd3; wr_score = 8'h55;
    tick();
    ac_button = 1'b0; wr_req = 1'b0;
    ref_mem[3] = 8'h55;
    exp_uid = next_uid(exp_uid);
    n_checks++; if (wr_ack !== 1'b1 || ram_we !== 1'b1) begin n_fails++; $display("[TB] FAIL pw_write_first: got ack %0b we %0b expected 1 1", wr_ack, ram_we); end
    n_checks++; if (ram_addr !== 3'd3 || ram_wdata !== 8'h55) begin n_fails++; $display("[TB] FAIL pw_write_addr: got addr %0d data %0h expected 3 55", ram_addr, ram_wdata); end
    n_checks++; if (userID !== 3'(exp_uid)) begin n_fails++; $display("[TB] FAIL pw_uid: got %0d expected %0d", userID, exp_uid); end
    tick();
    wait_valid(20, to);
    n_checks++; if (to) begin n_fails++; $display("[TB] FAIL pw_read_timeout: got timeout expected capture"); end
    n_checks++; if (userID !== 3'(exp_uid) || currentUserScoreFromRam !== ref_mem[exp_uid]) begin n_fails++; $display("[TB] FAIL pw_read: got uid %0d score %0h expected uid %0d score %0h", userID, currentUserScoreFromRam, exp_uid, ref_mem[exp_uid]); end
  endtask

  task automatic test_write_refresh();
    bit to, got;
    goto_user(2);
    do_write(2, 8'h99, got);
    n_checks++; if (!got || ram_we !== 1'b1 || ram_addr !== 3'd2) begin n_fails++; $display("[TB] FAIL wr_issue: got ack %0b we %0b addr %0d expected 1 1 2", got, ram_we, ram_addr); end
    tick();
    n_checks++; if (score_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL wr_valid_drop: got %0b expected 0", score_valid); end
    wait_valid(20, to);
    n_checks++; if (to || currentUserScoreFromRam !== 8'h99 || userID !== 3'd2) begin n_fails++; $display("[TB] FAIL wr_refresh: got timeout %0b score %0h uid %0d expected 0 99 2", to, currentUserScoreFromRam, userID); end
  endtask

  task automatic test_write_during_read();
    bit to, got;
    int slot;
    do_press();
    exp_uid = next_uid(exp_uid);
    tick();
    slot = (exp_uid + 3) % NUM_USERS;
    do_write(slot, 8'($urandom), got);
    n_checks++; if (!got) begin n_fails++; $display("[TB] FAIL wdr_ack_timeout: got no ack expected ack"); end
    n_checks++; if (score_valid !== 1'b1 || currentUserScoreFromRam !== ref_mem[exp_uid]) begin n_fails++; $display("[TB] FAIL wdr_read_first: got valid %0b score %0h expected 1 %0h", score_valid, currentUserScoreFromRam, ref_mem[exp_uid]); end
    n_checks++; if (ram_we !== 1'b1 || ram_addr !== 3'(slot)) begin n_fails++; $display("[TB] FAIL wdr_write: got we %0b addr %0d expected 1 %0d", ram_we, ram_addr, slot); end
    tick();
    wait_valid(20, to);
  endtask

  task automatic test_back_to_back();
    bit to;
    do_press();
    exp_uid = next_uid(exp_uid);
    tick();
    ac_button = 1'b1;
    tick();
    ac_button = 1'b0;
    exp_uid = next_uid(exp_uid);
    n_checks++; if (userID !== 3'(exp_uid) || busy !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_second_press: got uid %0d busy %0b expected %0d 1", userID, busy, exp_uid); end
    tick();
    ac_button = 1'b1;
    tick();
    ac_button = 1'b0;
    n_checks++; if (userID !== 3'(exp_uid) || score_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_third_dropped: got uid %0d valid %0b expected %0d 0", userID, score_valid, exp_uid); end
    wait_valid(20, to);
    n_checks++; if (to || userID !== 3'(exp_uid) || currentUserScoreFromRam !== ref_mem[exp_uid]) begin n_fails++; $display("[TB] FAIL b2b_final: got timeout %0b uid %0d score %0h expected 0 %0d %0h", to, userID, currentUserScoreFromRam, exp_uid, ref_mem[exp_uid]); end
  endtask

  task automatic test_random_writes();
    bit to, got;
    int slot;
    logic [SCORE_W-1:0] d;
    for (int w = 0; w < 6; w++) begin
      slot = int'($urandom_range(0, NUM_USERS - 1));
      d    = 8'($urandom);
      do_write(slot, d, got);
      n_checks++; if (!got || ram_we !== 1'b1 || ram_addr !== 3'(slot) || ram_wdata !== d) begin n_fails++; $display("[TB] FAIL rw_issue: got ack %0b we %0b addr %0d data %0h expected 1 1 %0d %0h", got, ram_we, ram_addr, ram_wdata, slot, d); end
      tick();
      wait_valid(20, to);
    end
    for (int p = 0; p < NUM_USERS; p++) begin
      do_press();
      exp_uid = next_uid(exp_uid);
      wait_valid(20, to);
      n_checks++; if (to || userID !== 3'(exp_uid) || currentUserScoreFromRam !== ref_mem[exp_uid]) begin n_fails++; $display("[TB] FAIL rw_browse: got timeout %0b uid %0d score %0h expected 0 %0d %0h", to, userID, currentUserScoreFromRam, exp_uid, ref_mem[exp_uid]); end
    end
  endtask

  task automatic test_access_drop();
    bit to;
    logic [SCORE_W-1:0] old;
    old = ref_mem[exp_uid];
    if (ref_mem[next_uid(exp_uid)] == old) preload(next_uid(exp_uid), old ^ 8'hFF);
    do_press();
    tick();
    access_granted = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || userID !== 3'd0 || score_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL drop_abort: got busy %0b uid %0d valid %0b expected 0 0 0", busy, userID, score_valid); end
    tick(); tick(); tick();
    n_checks++; if (score_valid !== 1'b0 || currentUserScoreFromRam !== old) begin n_fails++; $display("[TB] FAIL drop_no_capture: got valid %0b score %0h expected 0 %0h", score_valid, currentUserScoreFromRam, old); end
    access_granted = 1'b1;
    exp_uid = 0;
    wait_valid(20, to);
    n_checks++; if (to || userID !== 3'd0 || currentUserScoreFromRam !== ref_mem[0]) begin n_fails++; $display("[TB] FAIL regrant_autoread: got timeout %0b uid %0d score %0h expected 0 0 %0h", to, userID, currentUserScoreFromRam, ref_mem[0]); end
  endtask

  task automatic test_frozen();
    bit got;
    scoreRst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      do_press();
      tick();
      n_checks++; if (userID !== 3'(exp_uid) || busy !== 1'b0) begin n_fails++; $display("[TB] FAIL frozen_press: press %0d got uid %0d busy %0b expected %0d 0", p, userID, busy, exp_uid); end
    end
    do_write(7, 8'($urandom), got);
    n_checks++; if (!got || ram_we !== 1'b0) begin n_fails++; $display("[TB] FAIL bad_slot_write: got ack %0b we %0b expected 1 0", got, ram_we); end
    scoreRst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_press();
    test_round_robin();
    test_press_with_write();
    test_write_refresh();
    test_write_during_read();
    test_back_to_back();
    test_random_writes();
    test_access_drop();
    test_frozen();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
